seq_divider: RTL

- Iterative unsigned restoring divider that feeds the ALU's pass-through data input `di`; the ALU forwards `di` for op_div.
- The control unit starts it on a div instruction, stalls while `busy`=1, and captures `res` through the ALU when `done` pulses.
- One quotient bit per clock; result held stable until the next accepted start.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_div_step.sv | 40 ++++
 rtl/seq_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the result-select codes latched with a start request.
package seq_divider_pkg;

  // Controller states. Value 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // rem_sel codes: which registered result is driven onto res.
  localparam logic RES_QUO = 1'b0;
  localparam logic RES_REM = 1'b1;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// div_step
// One purely combinational restoring-division step.
//   p_i       : current partial remainder (always < divisor_i)
//   msb_i     : dividend bit shifted into the partial remainder
//   divisor_i : denominator
//   p_o       : next partial remainder
//   q_bit_o   : quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH-1:0] diff_s;

  // The shifted remainder needs WIDTH+1 bits for the compare. After a
  // successful subtract the result is below the divisor, so a WIDTH-bit
  // modular difference is already exact.
  assign p_shift_s = {p_i, msb_i};
  assign diff_s    = p_shift_s[WIDTH-1:0] - divisor_i;

  // Restore-or-subtract decision.
  always_comb begin
    p_o     = p_shift_s[WIDTH-1:0];
    q_bit_o = 1'b0;
    if (p_shift_s >= {1'b0, divisor_i}) begin
      p_o     = diff_s;
      q_bit_o = 1'b1;
    end else begin
      p_o     = p_shift_s[WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// A start taken in IDLE or DONE latches the operands; a zero divisor
// completes at once with quo = all ones, rem = dividend, dz = 1.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   start    : request, accepted when not busy
//   rem_sel  : 0 = res shows quotient, 1 = res shows remainder
//   dividend : numerator (latched with start)
//   divisor  : denominator (latched with start)
//   res      : selected registered result
//   quo/rem  : registered quotient / remainder of last completion
//   busy     : high while iterating
//   done     : high in the cycle the result becomes valid
//   dz       : divide-by-zero flag of the last completed operation
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rem_sel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_p_s;
  logic             step_q_bit_s;
  logic             accept_s;
  logic             last_step_s;
  logic             busy_s;
  logic             done_s;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i      (p_q),
    .msb_i    (d_q[WIDTH-1]),
    .divisor_i(dvsr_q),
    .p_o      (step_p_s),
    .q_bit_o  (step_q_bit_s)
  );

  // Start is only honoured outside RUN; in RUN it is dropped, not queued.
  assign accept_s    = start && (state_q != RUN);
  assign last_step_s = (cnt_q == CW'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode; these are pure decodes of the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
      RUN:     begin busy_s = 1'b1; done_s = 1'b0; end
      DONE:    begin busy_s = 1'b0; done_s = 1'b1; end
      default: begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Datapath next-state: operand capture, iteration and result write-back.
  always_comb begin
    cnt_d     = cnt_q;
    d_d       = d_q;
    dvsr_d    = dvsr_q;
    p_d       = p_q;
    rem_sel_d = rem_sel_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          d_d       = dividend;
          dvsr_d    = divisor;
          rem_sel_d = rem_sel;
          p_d       = '0;
          cnt_d     = CW'(WIDTH);
          if (divisor == '0) begin
            quo_d = '1;
            rem_d = dividend;
            dz_d  = 1'b1;
          end else begin
            dz_d  = dz_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        d_d   = {d_q[WIDTH-2:0], step_q_bit_s};
        p_d   = step_p_s;
        cnt_d = cnt_q - CW'(1);
        // The final step's results go straight to the output registers.
        if (last_step_s) begin
          quo_d = {d_q[WIDTH-2:0], step_q_bit_s};
          rem_d = step_p_s;
          dz_d  = 1'b0;
        end else begin
          dz_d  = dz_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      d_q       <= '0;
      dvsr_q    <= '0;
      p_q       <= '0;
      rem_sel_q <= RES_QUO;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      dvsr_q    <= dvsr_d;
      p_q       <= p_d;
      rem_sel_q <= rem_sel_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;
  assign res  = (rem_sel_q == RES_REM) ? rem_q : quo_q;
  assign busy = busy_s;
  assign done = done_s;

endmodule : seq_divider
